// File: rtl/shift_reg_bank_pkg.sv
// Shared types and helpers for the shift_reg_bank register bank.
package shift_reg_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_reg_bank_ff_stage.sv
// One WIDTH-bit register with clock enable and synchronous reset (reset wins over enable).
module ff_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             sr_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (sr_i) begin
      q_q <= RST_VAL;
    end else if (ce_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_reg_bank.sv
// DEPTH x WIDTH delay line: shift up/down, parallel load, hold, saturating fill counter.
// Optional registered tap output is enabled by defining SHIFT_REG_BANK_TAP_EN.
module shift_reg_bank
  import shift_reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       CK,
  input  logic                       SR,
  input  logic                       CE,
  input  logic [1:0]                 MODE,
  input  logic [WIDTH-1:0]           D,
  input  logic [WIDTH*DEPTH-1:0]     PD,
`ifdef SHIFT_REG_BANK_TAP_EN
  input  logic [$clog2(DEPTH)-1:0]   TAP_SEL,
  output logic [WIDTH-1:0]           TAP,
`endif
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Q0,
  output logic [WIDTH*DEPTH-1:0]     QP,
  output logic [fill_w(DEPTH)-1:0]   FILL,
  output logic                       FULL
);

  localparam int            FW       = fill_w(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  mode_t            mode;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [FW-1:0]    fill_q, fill_d;

  assign mode = mode_t'(MODE);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] up_src, dn_src, stage_d;

    if (i == 0) begin : g_up_in
      assign up_src = D;
    end else begin : g_up_chain
      assign up_src = stage_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_dn_in
      assign dn_src = D;
    end else begin : g_dn_chain
      assign dn_src = stage_q[i+1];
    end

    always_comb begin
      stage_d = stage_q[i];
      case (mode)
        MODE_UP:   stage_d = up_src;
        MODE_DOWN: stage_d = dn_src;
        MODE_LOAD: stage_d = PD[i*WIDTH +: WIDTH];
        default:   stage_d = stage_q[i];
      endcase
    end

    ff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i (CK),
      .sr_i  (SR),
      .ce_i  (CE),
      .d_i   (stage_d),
      .q_o   (stage_q[i])
    );

    assign QP[i*WIDTH +: WIDTH] = stage_q[i];
  end

  // Fill counts enabled shifts in either direction; it does not track per-direction validity.
  always_comb begin
    fill_d = fill_q;
    case (mode)
      MODE_UP, MODE_DOWN: if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      MODE_LOAD:          fill_d = FILL_MAX;
      default:            fill_d = fill_q;
    endcase
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      fill_q <= '0;
    end else if (CE) begin
      fill_q <= fill_d;
    end
  end

  assign FILL = fill_q;
  assign FULL = (fill_q == FILL_MAX);
  assign Q    = stage_q[DEPTH-1];
  assign Q0   = stage_q[0];

`ifdef SHIFT_REG_BANK_TAP_EN
  logic [WIDTH-1:0] tap_q, tap_d;

  // Selects beyond the last stage read back as the reset value.
  always_comb begin
    tap_d = RST_VAL;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(TAP_SEL) == k) tap_d = stage_q[k];
    end
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      tap_q <= RST_VAL;
    end else begin
      tap_q <= tap_d;
    end
  end

  assign TAP = tap_q;
`endif

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed-vector bench for shift_reg_bank (WIDTH=8, DEPTH=4); tap checks need SHIFT_REG_BANK_TAP_EN.
module tb_shift_reg_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int EW    = WIDTH*DEPTH + 3 + 1;

  logic                   CK = 1'b0;
  logic                   SR, CE;
  logic [1:0]             MODE;
  logic [WIDTH-1:0]       D;
  logic [WIDTH*DEPTH-1:0] PD;
  logic [WIDTH-1:0]       Q, Q0;
  logic [WIDTH*DEPTH-1:0] QP;
  logic [2:0]             FILL;
  logic                   FULL;
`ifdef SHIFT_REG_BANK_TAP_EN
  logic [1:0]             TAP_SEL;
  logic [WIDTH-1:0]       TAP;
`endif

  int tests  = 0;
  int failed = 0;

  logic [EW-1:0] exp_q[$];
  logic [8:0]    tap_q[$];

  // Clock / reset
  always #5 CK = ~CK;

  shift_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
    .CK      (CK),
    .SR      (SR),
    .CE      (CE),
    .MODE    (MODE),
    .D       (D),
    .PD      (PD),
`ifdef SHIFT_REG_BANK_TAP_EN
    .TAP_SEL (TAP_SEL),
    .TAP     (TAP),
`endif
    .Q       (Q),
    .Q0      (Q0),
    .QP      (QP),
    .FILL    (FILL),
    .FULL    (FULL)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, then queue the hand-computed result of that edge.
  task automatic step(input logic sr, input logic ce, input logic [1:0] mode,
                      input logic [7:0] d, input logic [31:0] pd, input logic [1:0] sel,
                      input logic [31:0] eqp, input logic [2:0] efill,
                      input logic tchk, input logic [7:0] etap);
    SR = sr; CE = ce; MODE = mode; D = d; PD = pd;
`ifdef SHIFT_REG_BANK_TAP_EN
    TAP_SEL = sel;
`endif
    @(posedge CK);
    #1;
    exp_q.push_back({eqp, efill, (efill == 3'd4)});
    tap_q.push_back({tchk, etap});
  endtask

  // Scoreboard monitor: outputs are stable mid-cycle, compare on the falling edge.
  always @(negedge CK) begin
    logic [EW-1:0] e;
    logic [8:0]    t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tap_q.pop_front();
      check("QP",   QP,   e[35:4]);
      check("Q",    {24'h0, Q},  {24'h0, e[35:28]});
      check("Q0",   {24'h0, Q0}, {24'h0, e[11:4]});
      check("FILL", {29'h0, FILL}, {29'h0, e[3:1]});
      check("FULL", {31'h0, FULL}, {31'h0, e[0]});
`ifdef SHIFT_REG_BANK_TAP_EN
      if (t[8]) check("TAP", {24'h0, TAP}, {24'h0, t[7:0]});
`endif
    end
  end

  initial begin
    SR = 1'b1; CE = 1'b0; MODE = 2'b00; D = '0; PD = '0;
`ifdef SHIFT_REG_BANK_TAP_EN
    TAP_SEL = '0;
`endif
    // Reset with CE low, then CE-gated shift attempts.
    step(1, 0, 2'b01, 8'hFF, 32'h0, 2'd0, 32'h00000000, 3'd0, 1, 8'h00);
    for (int i = 0; i < 5; i++)
      step(0, 0, 2'b01, 8'hFF, 32'h0, 2'd0, 32'h00000000, 3'd0, 0, 8'h00);
    // Shift up fill to saturation.
    step(0, 1, 2'b01, 8'h11, 32'h0, 2'd0, 32'h00000011, 3'd1, 0, 8'h00);
    step(0, 1, 2'b01, 8'h22, 32'h0, 2'd0, 32'h00001122, 3'd2, 0, 8'h00);
    step(0, 1, 2'b01, 8'h33, 32'h0, 2'd0, 32'h00112233, 3'd3, 0, 8'h00);
    step(0, 1, 2'b01, 8'h44, 32'h0, 2'd0, 32'h11223344, 3'd4, 0, 8'h00);
    // Shift down once, then up again with FILL saturated, then hold.
    step(0, 1, 2'b10, 8'hAA, 32'h0, 2'd0, 32'hAA112233, 3'd4, 0, 8'h00);
    step(0, 1, 2'b01, 8'h55, 32'h0, 2'd0, 32'h11223355, 3'd4, 0, 8'h00);
    step(0, 1, 2'b00, 8'h77, 32'hFFFFFFFF, 2'd0, 32'h11223355, 3'd4, 0, 8'h00);
    // Parallel load, then stall while the tap select moves.
    step(0, 1, 2'b11, 8'h00, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF, 3'd4, 0, 8'h00);
    step(0, 0, 2'b11, 8'h00, 32'h12345678, 2'd2, 32'hDEADBEEF, 3'd4, 1, 8'hAD);
    step(0, 0, 2'b11, 8'h00, 32'h12345678, 2'd1, 32'hDEADBEEF, 3'd4, 1, 8'hBE);
    step(0, 0, 2'b01, 8'h99, 32'h12345678, 2'd3, 32'hDEADBEEF, 3'd4, 1, 8'hDE);
    // Reset mid-stream while enabled shifting.
    step(1, 0, 2'b00, 8'h00, 32'h0, 2'd0, 32'h00000000, 3'd0, 1, 8'h00);
    step(0, 1, 2'b01, 8'h01, 32'h0, 2'd0, 32'h00000001, 3'd1, 0, 8'h00);
    step(0, 1, 2'b01, 8'h02, 32'h0, 2'd0, 32'h00000102, 3'd2, 0, 8'h00);
    step(1, 1, 2'b01, 8'h99, 32'h0, 2'd0, 32'h00000000, 3'd0, 1, 8'h00);
    step(0, 1, 2'b01, 8'h5A, 32'h0, 2'd0, 32'h0000005A, 3'd1, 0, 8'h00);
    // Shift-down latency: first D word reaches Q0 after DEPTH enabled edges.
    step(0, 1, 2'b10, 8'h7E, 32'h0, 2'd0, 32'h7E000000, 3'd2, 0, 8'h00);
    step(0, 0, 2'b10, 8'hEE, 32'h0, 2'd0, 32'h7E000000, 3'd2, 0, 8'h00);
    step(0, 1, 2'b10, 8'h7F, 32'h0, 2'd0, 32'h7F7E0000, 3'd3, 0, 8'h00);
    step(0, 1, 2'b10, 8'h80, 32'h0, 2'd0, 32'h807F7E00, 3'd4, 0, 8'h00);
    step(0, 1, 2'b10, 8'h81, 32'h0, 2'd0, 32'h81807F7E, 3'd4, 0, 8'h00);

    CE = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CK);
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
